// File: rtl/serial_chunk_adder.sv
// Multi-cycle WIDTH-bit adder/subtractor that ripples one CHUNK-bit slice per clock, LSB first.
// Valid/ready handshakes on both sides; a finished result can hand over to a new operand same edge.
module serial_chunk_adder #(
  parameter int unsigned WIDTH = 16,
  parameter int unsigned CHUNK = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             c_out,
  output logic             ovf,
  output logic             busy
);

  localparam int unsigned NCHUNK = WIDTH / CHUNK;
  localparam int unsigned CntW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CntW-1:0]  LastCnt   = CntW'(NCHUNK - 1);
  localparam logic [WIDTH-1:0] ChunkMask = WIDTH'({CHUNK{1'b1}});

  if ((WIDTH % CHUNK) != 0) begin : gen_bad_chunk
    $error("CHUNK must divide WIDTH");
  end

  typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

  state_e           state_q;
  logic [WIDTH-1:0] a_q, b_q, sum_q;
  logic [CntW-1:0]  cnt_q;
  logic             carry_q, c_out_q, ovf_q, out_valid_q;

  logic [CHUNK-1:0] a_chunk, b_chunk, s_chunk;
  logic [CHUNK:0]   c_chain;
  logic [WIDTH-1:0] sum_upd;
  logic             accept;

  assign in_ready  = (state_q == StIdle) || ((state_q == StDone) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = out_valid_q;
  assign busy      = (state_q != StIdle);
  assign sum       = sum_q;
  assign c_out     = c_out_q;
  assign ovf       = ovf_q;

  // One CHUNK-wide ripple slice, selected by the chunk counter.
  always_comb begin
    a_chunk = CHUNK'(a_q >> (cnt_q * CHUNK));
    b_chunk = CHUNK'(b_q >> (cnt_q * CHUNK));
    s_chunk = '0;
    c_chain = '0;
    c_chain[0] = carry_q;
    for (int i = 0; i < CHUNK; i++) begin
      s_chunk[i]   = a_chunk[i] ^ b_chunk[i] ^ c_chain[i];
      c_chain[i+1] = (a_chunk[i] & b_chunk[i]) | (c_chain[i] & (a_chunk[i] ^ b_chunk[i]));
    end
    sum_upd = (sum_q & ~(ChunkMask << (cnt_q * CHUNK)))
            | (WIDTH'(s_chunk) << (cnt_q * CHUNK));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StIdle;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      cnt_q       <= '0;
      carry_q     <= 1'b0;
      c_out_q     <= 1'b0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else if (accept) begin
      // Subtraction runs as a + ~b + ~c_in.
      a_q         <= a;
      b_q         <= b ^ {WIDTH{sub}};
      carry_q     <= c_in ^ sub;
      cnt_q       <= '0;
      out_valid_q <= 1'b0;
      state_q     <= StRun;
    end else begin
      unique case (state_q)
        StRun: begin
          sum_q   <= sum_upd;
          carry_q <= c_chain[CHUNK];
          if (cnt_q == LastCnt) begin
            c_out_q     <= c_chain[CHUNK];
            ovf_q       <= c_chain[CHUNK] ^ c_chain[CHUNK-1];
            out_valid_q <= 1'b1;
            state_q     <= StDone;
          end else begin
            cnt_q <= cnt_q + CntW'(1);
          end
        end
        StDone: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_chunk_adder.sv
// Scoreboard bench: stimulus pushes model results, a negedge monitor pops them on each handshake.
module tb_serial_chunk_adder;

  parameter int unsigned CHUNK = 4;
  localparam int unsigned W      = 16;
  localparam int unsigned NCHUNK = W / CHUNK;

  typedef struct {
    logic [W-1:0] sum;
    logic         co;
    logic         ov;
    int           acc;
  } exp_t;

  logic         clk, rst_n, in_valid, in_ready, c_in, sub, out_valid, out_ready;
  logic         c_out, ovf, busy;
  logic [W-1:0] a, b, sum;

  serial_chunk_adder #(.WIDTH(W), .CHUNK(CHUNK)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .c_in(c_in), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .c_out(c_out), .ovf(ovf), .busy(busy)
  );

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;
  int   cyc = 0;
  int   ready_mode = 1;  // 0: hold low, 1: hold high, 2: random
  int   n_pushed = 0;
  int   n_done = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference: plain integer arithmetic, signed range for overflow.
  function automatic exp_t model(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                                 input logic tc, input logic ts);
    exp_t   e;
    longint ua = longint'(ta);
    longint ub = longint'(tb_);
    longint sa = longint'($signed(ta));
    longint sb_ = longint'($signed(tb_));
    longint ci = tc ? 64'd1 : 64'd0;
    longint r, sr;
    longint smax = (longint'(1) << (W - 1)) - 1;
    longint smin = -(longint'(1) << (W - 1));
    r  = ts ? (ua - ub - ci) : (ua + ub + ci);
    sr = ts ? (sa - sb_ - ci) : (sa + sb_ + ci);
    e.sum = W'(r);
    e.co  = ts ? (r >= 0) : (r >= (longint'(1) << W));
    e.ov  = (sr > smax) || (sr < smin);
    e.acc = 0;
    return e;
  endfunction

  always begin
    @(posedge clk);
    #1;
    case (ready_mode)
      0:       out_ready = 1'b0;
      1:       out_ready = 1'b1;
      default: out_ready = 1'($urandom_range(0, 1));
    endcase
  end

  task automatic issue_op(input logic [W-1:0] ta, input logic [W-1:0] tb_,
                          input logic tc, input logic ts);
    exp_t e;
    bit   ok = 0;
    a = ta; b = tb_; c_in = tc; sub = ts; in_valid = 1'b1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL accept_timeout: in_ready never rose (a=%0h b=%0h)", ta, tb_);
      in_valid = 1'b0;
      return;
    end
    e = model(ta, tb_, tc, ts);
    e.acc = cyc + 1;
    sb.push_back(e);
    n_pushed++;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    bit ok = 0;
    for (int i = 0; i < 300; i++) begin
      @(posedge clk);
      #2;
      if (sb.size() == 0 && !out_valid) begin
        ok = 1;
        break;
      end
    end
    if (!ok) begin
      checks++; errors++;
      $display("FAIL drain_timeout: %0d results outstanding", sb.size());
    end
  endtask

  // Monitor
  logic         prev_hold, prev_ov;
  logic [W-1:0] held_sum;
  logic         held_co, held_ov;
  int           first_cyc;

  always @(negedge clk) begin
    if (!rst_n) begin
      prev_hold = 1'b0;
      prev_ov   = 1'b0;
    end else begin
      if (out_valid && !prev_ov) first_cyc = cyc;
      if (prev_hold) begin
        chk("hold_valid", 64'(out_valid), 64'd1);
        chk("hold_sum", 64'(sum), 64'(held_sum));
        chk("hold_c_out", 64'(c_out), 64'(held_co));
        chk("hold_ovf", 64'(ovf), 64'(held_ov));
      end
      if (out_valid && !out_ready) chk("hold_in_ready", 64'(in_ready), 64'd0);
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++; errors++;
          $display("FAIL spurious_out_valid: got sum=%0h with nothing expected", sum);
        end else begin
          exp_t e;
          e = sb.pop_front();
          chk("sum", 64'(sum), 64'(e.sum));
          chk("c_out", 64'(c_out), 64'(e.co));
          chk("ovf", 64'(ovf), 64'(e.ov));
          chk("latency", 64'(first_cyc - e.acc), 64'(NCHUNK));
          n_done++;
        end
      end
      prev_hold = out_valid && !out_ready;
      held_sum  = sum;
      held_co   = c_out;
      held_ov   = ovf;
      prev_ov   = out_valid;
    end
  end

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; c_in = 1'b0; sub = 1'b0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_c_out", 64'(c_out), 64'd0);
    chk("rst_ovf", 64'(ovf), 64'd0);
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    repeat (5) @(posedge clk);
    #1;
    chk("idle_out_valid", 64'(out_valid), 64'd0);

    // Directed add/sub corners
    issue_op(16'hFFFF, 16'h0001, 1'b0, 1'b0); drain();
    issue_op(16'h7FFF, 16'h0001, 1'b0, 1'b0); drain();
    issue_op(16'h0005, 16'h0007, 1'b0, 1'b1); drain();
    issue_op(16'h8000, 16'h0001, 1'b1, 1'b1); drain();

    // Backpressure then same-edge consume + accept
    ready_mode = 0;
    issue_op(16'h1234, 16'h0FFF, 1'b0, 1'b0);
    for (int i = 0; i < 50 && !out_valid; i++) @(negedge clk);
    @(posedge clk);
    #1;
    fork
      issue_op(16'hA5A5, 16'h5A5A, 1'b1, 1'b1);
      begin
        repeat (10) @(posedge clk);
        ready_mode = 1;
      end
    join
    drain();

    // Reset in the middle of a run
    issue_op(16'h1111, 16'h2222, 1'b0, 1'b0);
    if (NCHUNK > 2) begin
      repeat (2) @(posedge clk);
    end
    #1 rst_n = 1'b0;
    sb.delete();
    n_pushed--;
    #1;
    chk("midrst_sum", 64'(sum), 64'd0);
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue_op(16'h1234, 16'h4321, 1'b1, 1'b0); drain();

    // Random traffic with random backpressure
    ready_mode = 2;
    for (int n = 0; n < 1000; n++) begin
      issue_op(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom));
      repeat ($urandom_range(0, 2)) @(posedge clk);
    end
    ready_mode = 1;
    drain();

    chk("ops_completed", 64'(n_done), 64'(n_pushed));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
